// File: rtl/tlb_pkg.sv
// Shared TLB/page-walker definitions: PTE layout, walker states, default geometry
// and the fill record exchanged with the TLB cache.
package tlb_pkg;

  localparam int unsigned DEF_LEVELS     = 3;
  localparam int unsigned DEF_VPN_BITS   = 9;
  localparam int unsigned DEF_PAGE_SHIFT = 12;
  localparam int unsigned DEF_PPN_W      = 44;
  localparam int unsigned DEF_PCID_W     = 12;

  localparam int unsigned PTE_V      = 0;
  localparam int unsigned PTE_R      = 1;
  localparam int unsigned PTE_W      = 2;
  localparam int unsigned PTE_X      = 3;
  localparam int unsigned PTE_PPN_LO = 10;
  localparam int unsigned PTE_PPN_HI = 53;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FILL,
    ST_FAULT
  } ptw_state_e;

  typedef struct packed {
    logic [63:0]           va;
    logic [63:0]           pa;
    logic [DEF_PCID_W-1:0] pcid;
  } fill_rec_t;

  localparam int unsigned FILL_REC_W = $bits(fill_rec_t);

  // Keeps the page-frame bits above off_bits and the VA offset below them.
  function automatic logic [63:0] splice_pa(input logic [63:0] frame,
                                            input logic [63:0] va,
                                            input int unsigned off_bits);
    logic [63:0] m;
    m = (64'd1 << off_bits) - 64'd1;
    return (frame & ~m) | (va & m);
  endfunction

endpackage

// File: rtl/tlb_ptw_if.sv
// Miss / memory / fill signal bundle of the page-table walker.
interface tlb_ptw_if
  import tlb_pkg::*;
#(
  parameter int unsigned PPN_W  = DEF_PPN_W,
  parameter int unsigned PCID_W = DEF_PCID_W
) ();

  logic              miss_valid;
  logic              miss_ready;
  logic [63:0]       miss_va;
  logic [PCID_W-1:0] miss_pcid;
  logic [PPN_W-1:0]  root_ppn;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [63:0]       mem_req_addr;
  logic              mem_rsp_valid;
  logic [63:0]       mem_rsp_data;

  logic              fill_valid;
  logic [63:0]       fill_va;
  logic [63:0]       fill_pa;
  logic [PCID_W-1:0] fill_pcid;
  logic              fault;
  logic              busy;

  modport master (
    input  miss_valid, miss_va, miss_pcid, root_ppn,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output miss_ready, mem_req_valid, mem_req_addr,
           fill_valid, fill_va, fill_pa, fill_pcid, fault, busy
  );

  modport slave (
    output miss_valid, miss_va, miss_pcid, root_ppn,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  miss_ready, mem_req_valid, mem_req_addr,
           fill_valid, fill_va, fill_pa, fill_pcid, fault, busy
  );

endinterface

// File: rtl/tlb_pte_decode.sv
// Combinational PTE classifier: invalid / leaf / misaligned-superpage and next PPN.
module tlb_pte_decode
  import tlb_pkg::*;
#(
  parameter int unsigned LEVELS   = DEF_LEVELS,
  parameter int unsigned VPN_BITS = DEF_VPN_BITS,
  parameter int unsigned PPN_W    = DEF_PPN_W,
  localparam int unsigned LVL_W   = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic [63:0]      i_pte,
  input  logic [LVL_W-1:0] i_level,
  output logic             o_is_leaf,
  output logic             o_is_invalid,
  output logic             o_is_misaligned,
  output logic [PPN_W-1:0] o_next_ppn
);

  logic [PPN_W-1:0] w_low_mask;
  logic             w_unused;

  assign o_next_ppn   = i_pte[PTE_PPN_LO +: PPN_W];
  assign o_is_invalid = !i_pte[PTE_V] || (i_pte[PTE_W] && !i_pte[PTE_R]);
  assign o_is_leaf    = i_pte[PTE_R] || i_pte[PTE_X];
  assign w_unused     = ^{i_pte[63:PTE_PPN_LO+PPN_W], i_pte[PTE_PPN_LO-1:PTE_X+1]};

  // A superpage at level L must have its low VPN_BITS*L PPN bits clear.
  always_comb begin
    w_low_mask = '0;
    for (int unsigned l = 1; l < LEVELS; l++) begin
      if (i_level == LVL_W'(l))
        w_low_mask = (PPN_W'(1) << (VPN_BITS * l)) - PPN_W'(1);
    end
  end

  assign o_is_misaligned = o_is_leaf && (|(o_next_ppn & w_low_mask));

endmodule

// File: rtl/tlb_ptw.sv
// Single-walk Sv39-style page-table walker feeding TLB fills or page faults.
module tlb_ptw
  import tlb_pkg::*;
#(
  parameter int unsigned LEVELS     = DEF_LEVELS,
  parameter int unsigned VPN_BITS   = DEF_VPN_BITS,
  parameter int unsigned PAGE_SHIFT = DEF_PAGE_SHIFT,
  parameter int unsigned PPN_W      = DEF_PPN_W,
  parameter int unsigned PCID_W     = DEF_PCID_W
) (
  input  logic      clk,
  input  logic      rst,
  tlb_ptw_if.master bus
);

  localparam int unsigned LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  ptw_state_e        r_state, w_state_nxt;
  logic [63:0]       r_va, w_va_nxt;
  logic [PCID_W-1:0] r_pcid, w_pcid_nxt;
  logic [PPN_W-1:0]  r_ppn, w_ppn_nxt;
  logic [LVL_W-1:0]  r_level, w_level_nxt;
  logic [63:0]       r_pa, w_pa_nxt;

  logic [VPN_BITS-1:0] w_vpn;
  logic [63:0]         w_req_addr;
  logic [63:0]         w_leaf_pa;
  logic                w_is_leaf, w_is_invalid, w_is_misaligned;
  logic [PPN_W-1:0]    w_next_ppn;

  assign w_vpn      = r_va[PAGE_SHIFT + VPN_BITS*r_level +: VPN_BITS];
  assign w_req_addr = (64'(r_ppn) << PAGE_SHIFT) + (64'(w_vpn) << 3);
  assign w_leaf_pa  = splice_pa(64'(w_next_ppn) << PAGE_SHIFT, r_va,
                                PAGE_SHIFT + VPN_BITS*32'(r_level));

  tlb_pte_decode #(
    .LEVELS   (LEVELS),
    .VPN_BITS (VPN_BITS),
    .PPN_W    (PPN_W)
  ) u_decode (
    .i_pte           (bus.mem_rsp_data),
    .i_level         (r_level),
    .o_is_leaf       (w_is_leaf),
    .o_is_invalid    (w_is_invalid),
    .o_is_misaligned (w_is_misaligned),
    .o_next_ppn      (w_next_ppn)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_va    <= '0;
      r_pcid  <= '0;
      r_ppn   <= '0;
      r_level <= '0;
      r_pa    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_va    <= w_va_nxt;
      r_pcid  <= w_pcid_nxt;
      r_ppn   <= w_ppn_nxt;
      r_level <= w_level_nxt;
      r_pa    <= w_pa_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_va_nxt          = r_va;
    w_pcid_nxt        = r_pcid;
    w_ppn_nxt         = r_ppn;
    w_level_nxt       = r_level;
    w_pa_nxt          = r_pa;
    bus.miss_ready    = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = '0;
    bus.fill_valid    = 1'b0;
    bus.fill_va       = '0;
    bus.fill_pa       = '0;
    bus.fill_pcid     = '0;
    bus.fault         = 1'b0;
    bus.busy          = 1'b1;

    unique case (r_state)
      ST_IDLE: begin
        bus.busy       = 1'b0;
        bus.miss_ready = 1'b1;
        if (bus.miss_valid) begin
          w_va_nxt    = bus.miss_va;
          w_pcid_nxt  = bus.miss_pcid;
          w_ppn_nxt   = bus.root_ppn;
          w_level_nxt = LVL_W'(LEVELS - 1);
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = w_req_addr;
        if (bus.mem_req_ready)
          w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid) begin
          if (w_is_invalid) begin
            w_state_nxt = ST_FAULT;
          end else if (w_is_leaf) begin
            if (w_is_misaligned) begin
              w_state_nxt = ST_FAULT;
            end else begin
              w_pa_nxt    = w_leaf_pa;
              w_state_nxt = ST_FILL;
            end
          end else if (r_level == '0) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_ppn_nxt   = w_next_ppn;
            w_level_nxt = r_level - LVL_W'(1);
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_FILL: begin
        bus.fill_valid = 1'b1;
        bus.fill_va    = {r_va[63:PAGE_SHIFT], {PAGE_SHIFT{1'b0}}};
        bus.fill_pa    = r_pa;
        bus.fill_pcid  = r_pcid;
        w_state_nxt    = ST_IDLE;
      end
      ST_FAULT: begin
        bus.fault      = 1'b1;
        bus.fill_va    = {r_va[63:PAGE_SHIFT], {PAGE_SHIFT{1'b0}}};
        bus.fill_pcid  = r_pcid;
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_ptw.sv
// Randomized and directed checks of tlb_ptw against a walk model over a sparse memory.
module tb_tlb_ptw;
  import tlb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tlb_ptw_if #(.PPN_W(44), .PCID_W(12)) bus ();

  tlb_ptw #(
    .LEVELS     (3),
    .VPN_BITS   (9),
    .PAGE_SHIFT (12),
    .PPN_W      (44),
    .PCID_W     (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit [63:0]   mem [bit [63:0]];
  bit [63:0]   req_log [$];
  bit [63:0]   exp_addrs [$];
  int unsigned stall_cfg  = 0;
  int unsigned rsp_extra  = 0;
  bit          rand_stall = 1'b0;
  bit          junk_en    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory side: one outstanding read, response after 1+rsp_extra cycles.
  initial begin
    int unsigned rsp_wait   = 0;
    int unsigned stall_left = 0;
    bit [63:0]   rsp_pend   = '0;
    bit [63:0]   prev_addr  = '0;
    bit          prev_stall = 1'b0;
    bit          prev_busy  = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      if (junk_en) bus.mem_rsp_data = {$urandom, $urandom};
      if (rsp_wait != 0) begin
        rsp_wait--;
        if (rsp_wait == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = rsp_pend;
        end
      end else if (junk_en && $urandom_range(0, 7) == 0) begin
        bus.mem_rsp_valid = 1'b1;
      end
      if (bus.busy && !prev_busy) begin
        req_log.delete();
        stall_left = stall_cfg;
      end
      prev_busy = bus.busy;
      if (stall_left != 0 && bus.mem_req_valid) begin
        bus.mem_req_ready = 1'b0;
        stall_left--;
      end else if (rand_stall) begin
        bus.mem_req_ready = ($urandom_range(0, 2) != 0);
      end else begin
        bus.mem_req_ready = 1'b1;
      end
      if (prev_stall && !rst) begin
        chk("req_hold_valid", bus.mem_req_valid, 1'b1);
        chk("req_hold_addr", bus.mem_req_addr, prev_addr);
      end
      prev_stall = bus.mem_req_valid && !bus.mem_req_ready && !rst;
      prev_addr  = bus.mem_req_addr;
      if (bus.mem_req_valid && bus.mem_req_ready && !rst) begin
        req_log.push_back(bus.mem_req_addr);
        rsp_pend = mem.exists(bus.mem_req_addr) ? mem[bus.mem_req_addr] : 64'h0;
        rsp_wait = 1 + rsp_extra;
      end
    end
  end

  // Reference walk: table index arithmetic straight from the page-table rules.
  function automatic void model(input bit [63:0] va, input bit [43:0] root,
                                output bit flt, output bit [63:0] pa);
    bit [63:0] base, a, pte, nppn, span;
    exp_addrs.delete();
    flt  = 1'b1;
    pa   = '0;
    base = 64'(root) * 4096;
    for (int l = 2; l >= 0; l--) begin
      a = base + ((va / (64'd1 << (12 + 9*l))) % 512) * 8;
      exp_addrs.push_back(a);
      pte  = mem.exists(a) ? mem[a] : 64'h0;
      nppn = (pte >> 10) % (64'd1 << 44);
      if (pte[0] == 1'b0 || (pte[2] && !pte[1])) return;
      if (pte[1] || pte[3]) begin
        span = 64'd1 << (9*l);
        if (nppn % span != 0) return;
        pa  = nppn * 4096 + va % (span * 4096);
        flt = 1'b0;
        return;
      end
      if (l == 0) return;
      base = nppn * 4096;
    end
  endfunction

  task automatic build_random(input bit [63:0] va, input bit [43:0] root);
    bit [63:0] base, a, pte, ppn;
    bit [3:0]  perm;
    int        kind;
    mem.delete();
    base = 64'(root) * 4096;
    for (int l = 2; l >= 0; l--) begin
      a    = base + ((va >> (12 + 9*l)) & 64'h1ff) * 8;
      ppn  = {$urandom, $urandom} & ((64'd1 << 44) - 1);
      kind = $urandom_range(0, 9);
      if (kind == 0)      perm = {3'($urandom), 1'b0};
      else if (kind == 1) perm = {1'($urandom), 3'b101};
      else if (kind <= 4) begin
        case ($urandom_range(0, 4))
          0: perm = 4'b0011;
          1: perm = 4'b0111;
          2: perm = 4'b1001;
          3: perm = 4'b1011;
          default: perm = 4'b1111;
        endcase
        if (l > 0 && $urandom_range(0, 2) != 0) ppn = ppn & ~((64'd1 << (9*l)) - 1);
      end else perm = 4'b0001;
      pte = {10'($urandom), ppn[43:0], 2'($urandom), 4'($urandom), perm};
      mem[a] = pte;
      if (kind <= 4) break;
      base = ppn * 4096;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/miss_ready"}, bus.miss_ready, 1'b1);
    chk({tag, "/busy"}, bus.busy, 1'b0);
    chk({tag, "/req_valid"}, bus.mem_req_valid, 1'b0);
    chk({tag, "/req_addr"}, bus.mem_req_addr, 64'h0);
    chk({tag, "/fill_valid"}, bus.fill_valid, 1'b0);
    chk({tag, "/fill_va"}, bus.fill_va, 64'h0);
    chk({tag, "/fill_pa"}, bus.fill_pa, 64'h0);
    chk({tag, "/fill_pcid"}, 64'(bus.fill_pcid), 64'h0);
    chk({tag, "/fault"}, bus.fault, 1'b0);
  endtask

  task automatic start_miss(input bit [63:0] va, input bit [11:0] pcid, input bit [43:0] root,
                            output int unsigned t0);
    int unsigned w = 0;
    while (!bus.miss_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("miss_ready_before", bus.miss_ready, 1'b1);
    bus.miss_valid = 1'b1;
    bus.miss_va    = va;
    bus.miss_pcid  = pcid;
    bus.root_ppn   = root;
    t0 = cyc;
    @(negedge clk);
    bus.miss_valid = 1'b0;
    bus.miss_va    = {$urandom, $urandom};
    bus.miss_pcid  = 12'($urandom);
    bus.root_ppn   = 44'({$urandom, $urandom});
    chk("busy_after_accept", bus.busy, 1'b1);
  endtask

  task automatic run_walk(input string name, input bit [63:0] va, input bit [11:0] pcid,
                          input bit [43:0] root, input int exp_lat);
    bit          exp_fault;
    bit [63:0]   exp_pa;
    int unsigned t0;
    bit          done = 1'b0;
    model(va, root, exp_fault, exp_pa);
    start_miss(va, pcid, root, t0);
    for (int w = 0; w < 300 && !done; w++) begin
      if (bus.fill_valid || bus.fault) done = 1'b1;
      else @(negedge clk);
    end
    chk({name, "/completed"}, done, 1'b1);
    if (!done) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    chk({name, "/fault"}, bus.fault, exp_fault);
    chk({name, "/fill_valid"}, bus.fill_valid, !exp_fault);
    chk({name, "/fill_va"}, bus.fill_va, va & ~64'hfff);
    chk({name, "/fill_pcid"}, 64'(bus.fill_pcid), 64'(pcid));
    if (!exp_fault) chk({name, "/fill_pa"}, bus.fill_pa, exp_pa);
    if (exp_lat >= 0) chk({name, "/latency"}, 64'(cyc - t0), 64'(exp_lat));
    chk({name, "/n_req"}, 64'(req_log.size()), 64'(exp_addrs.size()));
    for (int i = 0; i < req_log.size() && i < exp_addrs.size(); i++)
      chk({name, "/req_addr"}, req_log[i], exp_addrs[i]);
    @(negedge clk);
    chk({name, "/pulse_end_fill"}, bus.fill_valid, 1'b0);
    chk({name, "/pulse_end_fault"}, bus.fault, 1'b0);
    chk({name, "/ready_after"}, bus.miss_ready, 1'b1);
  endtask

  task automatic load_test1();
    mem.delete();
    mem[64'h100008] = 64'h40401;
    mem[64'h101008] = 64'h40801;
    mem[64'h102018] = 64'h2000000F;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    int          events;
    bus.miss_valid = 1'b0;
    bus.miss_va    = '0;
    bus.miss_pcid  = '0;
    bus.root_ppn   = '0;
    repeat (3) @(negedge clk);
    chk_idle("in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("after_reset");

    load_test1();
    run_walk("walk4k", 64'h40203abc, 12'h5, 44'h100, 7);
    mem[64'h101008] = 64'h2008000B;
    run_walk("super2m", 64'h40203abc, 12'h5, 44'h100, 5);
    mem[64'h101008] = 64'h2008040B;
    run_walk("misaligned", 64'h40203abc, 12'h5, 44'h100, 5);
    mem.delete();
    run_walk("invalid", 64'h40203abc, 12'h9, 44'h100, 3);
    load_test1();
    stall_cfg = 3;
    run_walk("backpressure", 64'h40203abc, 12'h5, 44'h100, 10);
    stall_cfg = 0;

    load_test1();
    rsp_extra = 4;
    start_miss(64'h40203abc, 12'h5, 44'h100, t0);
    for (int w = 0; w < 50 && req_log.size() < 2; w++) @(negedge clk);
    @(negedge clk);
    chk("rst_mid/busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_idle("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    events = 0;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      if (bus.fill_valid || bus.fault || bus.busy || bus.mem_req_valid) events++;
    end
    chk("rst_mid/stray_activity", 64'(events), 64'h0);
    rsp_extra = 0;
    run_walk("after_rst", 64'h40203abc, 12'h5, 44'h100, 7);

    rand_stall = 1'b1;
    junk_en    = 1'b1;
    for (int n = 0; n < 40; n++) begin
      bit [63:0] va;
      bit [43:0] root;
      va        = {$urandom, $urandom};
      root      = 44'($urandom_range(1, 32'hFFFFF));
      rsp_extra = $urandom_range(0, 2);
      build_random(va, root);
      run_walk("random", va, 12'($urandom), root, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_ptw.md
Name: tlb_ptw

Overview:
Hardware page-table walker that sits directly downstream of the TLB `cache` block.
- Consumes a TLB miss (VA + PCID) and walks a 3-level Sv39-style page table in memory.
- Returns a fill (page-aligned VA, PA, PCID) for the TLB to install, or a fault.
- Serves one walk at a time.
- Drives a single-outstanding memory read port with valid/ready request and valid-only response.

Parameters:
LEVELS, 3, number of page-table levels (top index LEVELS-1)
VPN_BITS, 9, VPN bits consumed per level
PAGE_SHIFT, 12, base page size log2 (4 KiB)
PPN_W, 44, physical page number width
PCID_W, 12, process-context ID width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
miss_valid  in  1  TLB miss request
miss_ready  out  1  walker idle, can accept a miss
miss_va  in  64  faulting virtual address
miss_pcid  in  PCID_W  PCID of the miss
root_ppn  in  PPN_W  root table PPN, sampled on miss accept
mem_req_valid  out  1  PTE read request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  64  PTE physical address
mem_rsp_valid  in  1  PTE data valid
mem_rsp_data  in  64  PTE
fill_valid  out  1  one-cycle fill pulse
fill_va  out  64  VA with low PAGE_SHIFT bits zeroed
fill_pa  out  64  translated PA of miss_va, offset included
fill_pcid  out  PCID_W  PCID of the fill
fault  out  1  one-cycle page-fault pulse
busy  out  1  walk in progress

Behaviour:
- Reset: async, active-high. State IDLE. miss_ready=1 after reset releases. All other outputs 0, including the captured va, pcid and ppn registers.
- FSM states: IDLE, REQ, WAIT, FILL, FAULT.
- IDLE:
  - miss_ready=1.
  - On miss_valid & miss_ready: capture va, pcid, root_ppn; set level=LEVELS-1; go to REQ.
- REQ:
  - mem_req_valid=1.
  - mem_req_addr = (ppn << PAGE_SHIFT) + (vpn[level] << 3), where vpn[l] = va[PAGE_SHIFT+VPN_BITS*l +: VPN_BITS].
  - Addr is held stable until mem_req_ready. On handshake go to WAIT.
- WAIT:
  - mem_rsp_valid is sampled only here; responses in any other state are ignored.
  - PTE fields: V=bit0, R=1, W=2, X=3, PPN=bits 53:10.
  - Invalid PTE (V=0, or W=1 & R=0) -> FAULT.
  - Leaf PTE (R|X) at level L:
    - If L>0 and PPN[VPN_BITS*L-1:0] != 0 (misaligned superpage) -> FAULT.
    - Otherwise compute the PA and go to FILL. PA = {PTE.PPN upper bits, va[PAGE_SHIFT+VPN_BITS*L-1:0]}.
  - Pointer PTE (V=1, R=X=0):
    - At level 0 -> FAULT.
    - Otherwise ppn <= PTE.PPN, level <= level-1, go to REQ.
- FILL: fill_valid=1 for exactly one cycle with fill_va/pa/pcid valid -> IDLE.
- FAULT: fault=1 for exactly one cycle. fill_va/fill_pcid carry the miss so the TLB can report it. fill_valid=0. Next state IDLE.
- busy=1 in every state except IDLE; miss_ready = !busy.
- Upper VA bits above bit 38 are ignored; no canonical check.
- Latency with zero-wait memory (ready=1, rsp one cycle after request):
  - Miss accepted at cycle 0; REQ at 1,3,5; WAIT at 2,4,6; fill at cycle 7; miss_ready=1 at cycle 8.
  - Each memory stall cycle adds one cycle.
- Reset asserted mid-walk: immediate return to IDLE, outputs zeroed, no fill/fault emitted. A late mem_rsp_valid after reset is ignored (state is IDLE).
- No new miss is accepted during FILL/FAULT; back-to-back misses are at least one IDLE cycle apart.

Decomposition:
- tlb_pkg holds:
  - PTE bit positions (PTE_V, PTE_R, PTE_W, PTE_X, PTE_PPN_LO/HI)
  - the state encoding
  - PAGE_SHIFT/VPN_BITS/PPN_W/PCID_W defaults
  - the fill-record width, shared with `cache`
- One combinational sub-module, tlb_pte_decode: takes PTE + level, outputs is_leaf, is_invalid, is_misaligned, next_ppn.

Test Plan:
1. 4 KiB walk. Stimulus: root_ppn=0x100, va=0x40203abc, pcid=0x5; memory [0x100008]=0x40401, [0x101008]=0x40801, [0x102018]=0x2000000F. Response: req addrs in order 0x100008, 0x101008, 0x102018; fill at cycle 7 with fill_va=0x40203000, fill_pa=0x80000abc, fill_pcid=0x5.
2. 2 MiB superpage. Same va; [0x101008]=0x2008000B. Response: two requests only; fill_pa=0x80203abc.
3. Misaligned superpage. [0x101008]=0x2008040B (PPN 0x80201). Response: fault pulse, no fill_valid; miss_ready=1 the next cycle.
4. Invalid PTE. [0x100008]=0x0. Response: fault one cycle after rsp; no further mem requests.
5. Backpressure. mem_req_ready low for 3 cycles on the first request. Response: mem_req_addr held at 0x100008 with valid=1 throughout; fill at cycle 10.
6. Reset mid-walk. Assert rst in WAIT at level 1, then drive a stray mem_rsp_valid. Response: immediate IDLE with all outputs 0; no fill/fault; the next miss walks normally.
